pool_fc_flatten: RTL and testbench
==================================

Name: pool_fc_flatten

Overview:
- Flatten stage between the last pooling layer and the first fully connected layer of the CNN pipeline.
- Accepts one parallel per-channel pixel vector at a time from the pool stage's o_func_data.
- Serialises each vector into the fc_layer input buffer through its i_ibuf_we / i_ibuf_wr_data / i_ibuf_addr write port, with back-pressure to the pool stage.
- After the last pixel of an image is written, issues i_start to the fc_layer and holds off the next image until the fc_layer finishes reading its buffer.

Parameters:
- input_channels, 256, channels per pixel vector (width of i_data array)
- num_pixels, 36, pixel vectors per image (6x6 after final pool)
- datatype_size, 2, bits per element
- input_size, input_channels*num_pixels, fc input length (9216 by default)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- i_valid  input  1  single-cycle pulse; i_data holds a pixel vector
- i_data  input  [datatype_size-1:0] x [input_channels-1:0]  pixel vector, element c is channel c
- o_busy  output  1  to pool stage i_next_busy; no i_valid may be issued while high
- o_ibuf_we  output  1  fc ibuf write enable
- o_ibuf_wr_data  output  datatype_size  fc ibuf write data
- o_ibuf_addr  output  $clog2(input_size)  fc ibuf write address
- o_fc_start  output  1  one-cycle pulse to fc i_start
- i_fc_busy  input  1  fc o_busy; rises the cycle after i_start, falls when fc computation completes
- o_err_drop  output  1  sticky flag; an i_valid arrived while o_busy was high

Behaviour:
- Reset (rst=0, asynchronous):
  - all outputs 0
  - state IDLE, pixel_cnt=0, ch_cnt=0, capture register cleared
- Reset mid-operation aborts any partial image. No o_fc_start is issued for it.
- All outputs are registered, except o_busy = (state != IDLE), which decodes the registered state.
- IDLE:
  - On i_valid, latch i_data into the capture register and go to SER. ch_cnt=0.
  - o_busy rises in the cycle after acceptance.
- SER, one write per cycle:
  - o_ibuf_we=1
  - o_ibuf_wr_data = cap[ch_cnt]
  - o_ibuf_addr = pixel_cnt*input_channels + ch_cnt (channel-minor, pixel-major)
  - ch_cnt increments each cycle.
  - At ch_cnt = input_channels-1:
    - if pixel_cnt < num_pixels-1: pixel_cnt++, go to IDLE
    - else: pixel_cnt=0, go to START
- Latency: accept at edge k means writes occupy cycles k+1 .. k+input_channels. o_busy is low again in cycle k+input_channels+1.
- START:
  - Wait while i_fc_busy=1.
  - When i_fc_busy=0, assert o_fc_start for exactly one cycle, then go to FC_RUN.
- FC_RUN:
  - Minimum one cycle.
  - Go to IDLE at the first cycle after entry in which i_fc_busy=0.
  - The fc input buffer is protected: no writes occur from START through FC_RUN.
- Error handling:
  - i_valid while o_busy=1 is ignored (no capture, no write) and sets o_err_drop.
  - o_err_drop clears only on reset.
- Widths:
  - o_ibuf_addr never exceeds input_size-1.
  - Counters are sized by $clog2 with no wrap beyond the terminal values above.
- Degenerate sizes: input_channels=1 or num_pixels=1 must work; SER lasts one cycle, or START follows the first vector.

Optional Feature:
- Macro: FLATTEN_OVERLAP_EN
- Defined:
  - A second holding register is added.
  - o_busy = holding register full, or state in {START, FC_RUN}.
  - A vector may be accepted while SER is running. It is transferred to the capture register and serialised immediately when SER ends, with no bubble cycle.
  - This applies only if it is not the first pixel of a new image while START/FC_RUN is pending.
- Undefined: behaviour exactly as above, one vector in flight.

Test Plan (input_channels=4, num_pixels=2, datatype_size=2 unless noted):
- Reset, then idle 10 cycles -> all outputs 0, no writes.
- i_valid with i_data={3,2,1,0} (ch3..ch0) -> writes addr0..3 = 0,1,2,3 on 4 consecutive cycles; o_busy high 4 cycles then low.
- Second vector {0,1,2,3} -> addr4..7 = 3,2,1,0. o_fc_start pulses one cycle after the last write (i_fc_busy=0). i_fc_busy held high 20 cycles -> o_busy stays high until i_fc_busy falls, then IDLE.
- i_fc_busy=1 when START is entered -> o_fc_start withheld until i_fc_busy drops, then a single pulse.
- i_valid pulsed during SER -> ignored, no extra write, o_err_drop=1 and stays 1.
- Reset asserted at the second write of a pixel -> outputs 0 immediately; the next image starts at addr0; o_fc_start only after a full 8 writes.

Source files
------------

// File: rtl/pool_fc_flatten_if.sv
// Bus bundle between the pool stage, the flatten stage and the fc_layer input buffer.
// The slave modport is the flatten stage; the master modport is its environment.
interface pool_fc_flatten_if #(
   parameter int INPUT_CHANNELS = 256,
   parameter int DATATYPE_SIZE  = 2,
   parameter int INPUT_SIZE     = 9216,
   parameter int ADDR_W         = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1
);
   logic                                         i_valid;
   logic [INPUT_CHANNELS-1:0][DATATYPE_SIZE-1:0] i_data;
   logic                                         o_busy;
   logic                                         o_ibuf_we;
   logic [DATATYPE_SIZE-1:0]                     o_ibuf_wr_data;
   logic [ADDR_W-1:0]                            o_ibuf_addr;
   logic                                         o_fc_start;
   logic                                         i_fc_busy;
   logic                                         o_err_drop;

   modport slave (
      input  i_valid, i_data, i_fc_busy,
      output o_busy, o_ibuf_we, o_ibuf_wr_data, o_ibuf_addr, o_fc_start, o_err_drop
   );

   modport master (
      output i_valid, i_data, i_fc_busy,
      input  o_busy, o_ibuf_we, o_ibuf_wr_data, o_ibuf_addr, o_fc_start, o_err_drop
   );
endinterface

// File: rtl/pool_fc_flatten.sv
// Flatten stage: serialises pooled pixel vectors into the fc input buffer, then starts the fc.
// Optional macro FLATTEN_OVERLAP_EN adds a holding register so a vector can be taken during SER.
module pool_fc_flatten #(
   parameter int INPUT_CHANNELS = 256,
   parameter int NUM_PIXELS     = 36,
   parameter int DATATYPE_SIZE  = 2,
   parameter int INPUT_SIZE     = INPUT_CHANNELS * NUM_PIXELS
) (
   input  logic                 clk,
   input  logic                 rst,
   pool_fc_flatten_if.slave     bus
);
   localparam int CH_W   = (INPUT_CHANNELS > 1) ? $clog2(INPUT_CHANNELS) : 1;
   localparam int PX_W   = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
   localparam int ADDR_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
   localparam int VEC_W  = INPUT_CHANNELS * DATATYPE_SIZE;

   localparam logic [CH_W-1:0] CH_LAST = CH_W'(INPUT_CHANNELS - 1);
   localparam logic [CH_W-1:0] CH_ONE  = CH_W'(1);
   localparam logic [PX_W-1:0] PX_LAST = PX_W'(NUM_PIXELS - 1);
   localparam logic [PX_W-1:0] PX_ONE  = PX_W'(1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SER   = 2'd1;
   localparam logic [1:0] ST_START = 2'd2;
   localparam logic [1:0] ST_RUN   = 2'd3;

   typedef logic [INPUT_CHANNELS-1:0][DATATYPE_SIZE-1:0] vec_t;

   logic [1:0]               state_q, state_d;
   logic [CH_W-1:0]          ch_cnt_q, ch_cnt_d;
   logic [PX_W-1:0]          pixel_cnt_q, pixel_cnt_d;
   vec_t                     cap_q, cap_d;
   logic                     we_q, we_d;
   logic [DATATYPE_SIZE-1:0] wr_data_q, wr_data_d;
   logic [ADDR_W-1:0]        addr_q, addr_d;
   logic                     fc_start_q, fc_start_d;
   logic                     err_drop_q, err_drop_d;
   logic                     busy_s;
   logic                     accept_s;

`ifdef FLATTEN_OVERLAP_EN
   vec_t                     hold_q, hold_d;
   logic                     hold_full_q, hold_full_d;

   // The last pixel of an image is never overlapped: the next vector belongs to a new image.
   assign busy_s = hold_full_q || (state_q == ST_START) || (state_q == ST_RUN) ||
                   ((state_q == ST_SER) && (pixel_cnt_q == PX_LAST));
`else
   assign busy_s = (state_q != ST_IDLE);
`endif

   assign accept_s = bus.i_valid && !busy_s;

   // Next-state logic for the FSM, counters, capture path and registered outputs.
   always_comb begin
      state_d     = state_q;
      ch_cnt_d    = ch_cnt_q;
      pixel_cnt_d = pixel_cnt_q;
      cap_d       = cap_q;
      fc_start_d  = 1'b0;
      err_drop_d  = err_drop_q || (bus.i_valid && busy_s);
`ifdef FLATTEN_OVERLAP_EN
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               cap_d    = bus.i_data;
               ch_cnt_d = {CH_W{1'b0}};
               state_d  = ST_SER;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_SER: begin
`ifdef FLATTEN_OVERLAP_EN
            if (accept_s) begin
               hold_d      = bus.i_data;
               hold_full_d = 1'b1;
            end else begin
               hold_d      = hold_q;
            end
`endif
            if (ch_cnt_q == CH_LAST) begin
               ch_cnt_d = {CH_W{1'b0}};
               if (pixel_cnt_q == PX_LAST) begin
                  pixel_cnt_d = {PX_W{1'b0}};
                  state_d     = ST_START;
                  fc_start_d  = !bus.i_fc_busy;
               end else begin
                  pixel_cnt_d = pixel_cnt_q + PX_ONE;
`ifdef FLATTEN_OVERLAP_EN
                  if (hold_full_d) begin
                     cap_d       = hold_d;
                     hold_full_d = 1'b0;
                     state_d     = ST_SER;
                  end else begin
                     state_d     = ST_IDLE;
                  end
`else
                  state_d     = ST_IDLE;
`endif
               end
            end else begin
               ch_cnt_d = ch_cnt_q + CH_ONE;
            end
         end
         ST_START: begin
            // The pulse is launched from START; once it has been out for a cycle, hand over.
            if (fc_start_q) begin
               state_d    = ST_RUN;
            end else begin
               fc_start_d = !bus.i_fc_busy;
            end
         end
         ST_RUN: begin
            if (!bus.i_fc_busy) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      we_d      = (state_d == ST_SER);
      wr_data_d = we_d ? cap_d[ch_cnt_d] : {DATATYPE_SIZE{1'b0}};
      addr_d    = we_d ? (ADDR_W'(pixel_cnt_d) * ADDR_W'(INPUT_CHANNELS) + ADDR_W'(ch_cnt_d))
                       : {ADDR_W{1'b0}};
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         ch_cnt_q    <= {CH_W{1'b0}};
         pixel_cnt_q <= {PX_W{1'b0}};
         cap_q       <= {VEC_W{1'b0}};
         we_q        <= 1'b0;
         wr_data_q   <= {DATATYPE_SIZE{1'b0}};
         addr_q      <= {ADDR_W{1'b0}};
         fc_start_q  <= 1'b0;
         err_drop_q  <= 1'b0;
`ifdef FLATTEN_OVERLAP_EN
         hold_q      <= {VEC_W{1'b0}};
         hold_full_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ch_cnt_q    <= ch_cnt_d;
         pixel_cnt_q <= pixel_cnt_d;
         cap_q       <= cap_d;
         we_q        <= we_d;
         wr_data_q   <= wr_data_d;
         addr_q      <= addr_d;
         fc_start_q  <= fc_start_d;
         err_drop_q  <= err_drop_d;
`ifdef FLATTEN_OVERLAP_EN
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
`endif
      end
   end

   assign bus.o_busy         = busy_s;
   assign bus.o_ibuf_we      = we_q;
   assign bus.o_ibuf_wr_data = wr_data_q;
   assign bus.o_ibuf_addr    = addr_q;
   assign bus.o_fc_start     = fc_start_q;
   assign bus.o_err_drop     = err_drop_q;
endmodule

// File: tb/tb_pool_fc_flatten.sv
// Self-checking bench for pool_fc_flatten (4 channels, 2 pixels, 2-bit elements):
// expected buffer writes are queued when a vector is sent and popped as writes appear.
module tb_pool_fc_flatten;
   localparam int C  = 4;
   localparam int N  = 2;
   localparam int D  = 2;
   localparam int IS = C * N;
   localparam int AW = 3;

   typedef logic [C-1:0][D-1:0] vec_t;
   typedef struct packed {
      logic [AW-1:0] addr;
      logic [D-1:0]  data;
   } wr_t;

   logic clk;
   logic rst;
   wr_t  exp_q[$];
   int   checks;
   int   errors;
   int   writes;
   int   writes_at_start;
   int   px;

   pool_fc_flatten_if #(.INPUT_CHANNELS(C), .DATATYPE_SIZE(D), .INPUT_SIZE(IS)) bus ();

   pool_fc_flatten #(.INPUT_CHANNELS(C), .NUM_PIXELS(N), .DATATYPE_SIZE(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to the next falling edge and score any buffer write seen there.
   task automatic step();
      wr_t e;
      @(negedge clk);
      if (bus.o_fc_start === 1'b1) writes_at_start = writes;
      if (bus.o_ibuf_we === 1'b1) begin
         writes++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write got addr=%0d data=%0d exp no write",
                     bus.o_ibuf_addr, bus.o_ibuf_wr_data);
         end else begin
            e = exp_q.pop_front();
            if (bus.o_ibuf_addr !== e.addr || bus.o_ibuf_wr_data !== e.data) begin
               errors++;
               $display("FAIL ibuf_write got addr=%0d data=%0d exp addr=%0d data=%0d",
                        bus.o_ibuf_addr, bus.o_ibuf_wr_data, e.addr, e.data);
            end
         end
      end
   endtask

   // Pulse i_valid for one cycle and queue the writes that vector must produce.
   task automatic drive_vec(input vec_t v);
      wr_t w;
      checks++;
      if (bus.o_busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_before_send got=%0b exp=0", bus.o_busy);
      end
      bus.i_data  = v;
      bus.i_valid = 1'b1;
      for (int c = 0; c < C; c++) begin
         w.addr = AW'(px * C + c);
         w.data = v[c];
         exp_q.push_back(w);
      end
      px = (px + 1) % N;
      step();
      bus.i_valid = 1'b0;
   endtask

   // Behave as the fc_layer: raise busy after i_start, hold it, drop it, expect IDLE.
   task automatic run_fc(input int hold, output int start_idx);
      int pulses;
      bit seen;
      pulses    = 0;
      seen      = 1'b0;
      start_idx = -1;
      for (int i = 0; i < 12 && !seen; i++) begin
         step();
         if (bus.o_fc_start === 1'b1) begin
            seen          = 1'b1;
            pulses++;
            start_idx     = i;
            bus.i_fc_busy = 1'b1;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL fc_start_timeout got=none exp=pulse within 12 cycles");
      end
      for (int i = 0; i < hold; i++) begin
         step();
         if (bus.o_fc_start === 1'b1) pulses++;
         checks++;
         if (bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_during_fc cycle=%0d got=%0b exp=1", i, bus.o_busy);
         end
      end
      bus.i_fc_busy = 1'b0;
      step();
      if (bus.o_fc_start === 1'b1) pulses++;
      checks++;
      if (bus.o_busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_after_fc got=%0b exp=0", bus.o_busy);
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL fc_start_pulses got=%0d exp=1", pulses);
      end
   endtask

   task automatic test_reset();
      logic [8:0] outs;
      rst           = 1'b0;
      bus.i_valid   = 1'b0;
      bus.i_data    = {C*D{1'b0}};
      bus.i_fc_busy = 1'b0;
      step();
      step();
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         outs = {bus.o_busy, bus.o_ibuf_we, bus.o_ibuf_wr_data, bus.o_ibuf_addr,
                 bus.o_fc_start, bus.o_err_drop};
         checks++;
         if (outs !== 9'd0) begin
            errors++;
            $display("FAIL reset_idle cycle=%0d got=%b exp=000000000", i, outs);
         end
      end
   endtask

   task automatic test_first_vector();
      drive_vec({2'd3, 2'd2, 2'd1, 2'd0});
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         checks++;
         if (bus.o_busy !== 1'b1 || bus.o_ibuf_we !== 1'b1) begin
            errors++;
            $display("FAIL ser_cycle %0d got busy=%0b we=%0b exp busy=1 we=1",
                     i, bus.o_busy, bus.o_ibuf_we);
         end
      end
      step();
      checks++;
      if (bus.o_busy !== 1'b0 || bus.o_ibuf_we !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL ser_end got busy=%0b we=%0b pending=%0d exp busy=0 we=0 pending=0",
                  bus.o_busy, bus.o_ibuf_we, exp_q.size());
      end
   endtask

   task automatic test_image_complete();
      int idx;
      drive_vec({2'd0, 2'd1, 2'd2, 2'd3});
      for (int i = 0; i < 3; i++) step();
      run_fc(20, idx);
      checks++;
      if (idx != 0) begin
         errors++;
         $display("FAIL fc_start_latency got=%0d exp=0 cycles after last write", idx);
      end
   endtask

   task automatic test_fc_busy_start();
      vec_t v;
      int   idx;
      bus.i_fc_busy = 1'b1;
      for (int p = 0; p < N; p++) begin
         for (int c = 0; c < C; c++) v[c] = D'($urandom_range(0, 3));
         drive_vec(v);
         for (int i = 0; i < 3; i++) step();
         if (p < N - 1) step();
      end
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (bus.o_fc_start !== 1'b0 || bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL start_withheld cycle=%0d got start=%0b busy=%0b exp start=0 busy=1",
                     i, bus.o_fc_start, bus.o_busy);
         end
      end
      bus.i_fc_busy = 1'b0;
      run_fc(3, idx);
      checks++;
      if (idx != 0) begin
         errors++;
         $display("FAIL start_after_busy_drop got=%0d exp=0", idx);
      end
   endtask

   task automatic test_drop();
      int wbase;
      int idx;
      checks++;
      if (bus.o_err_drop !== 1'b0) begin
         errors++;
         $display("FAIL err_drop_initial got=%0b exp=0", bus.o_err_drop);
      end
      wbase = writes;
      drive_vec({2'd1, 2'd3, 2'd0, 2'd2});
      step();
      bus.i_data  = {2'd2, 2'd2, 2'd2, 2'd2};
      bus.i_valid = 1'b1;
      step();
      bus.i_valid = 1'b0;
      checks++;
      if (bus.o_err_drop !== 1'b1) begin
         errors++;
         $display("FAIL err_drop_set got=%0b exp=1", bus.o_err_drop);
      end
      step();
      step();
      checks++;
      if (writes - wbase != C || exp_q.size() != 0 || bus.o_busy !== 1'b0) begin
         errors++;
         $display("FAIL drop_ignored got writes=%0d pending=%0d busy=%0b exp writes=%0d pending=0 busy=0",
                  writes - wbase, exp_q.size(), bus.o_busy, C);
      end
      drive_vec({2'd0, 2'd0, 2'd3, 2'd3});
      for (int i = 0; i < 3; i++) step();
      run_fc(2, idx);
      checks++;
      if (bus.o_err_drop !== 1'b1) begin
         errors++;
         $display("FAIL err_drop_sticky got=%0b exp=1", bus.o_err_drop);
      end
   endtask

   task automatic test_reset_mid();
      logic [8:0] outs;
      int wbase;
      int idx;
      drive_vec({2'd3, 2'd1, 2'd2, 2'd0});
      step();
      rst = 1'b0;
      #1;
      outs = {bus.o_busy, bus.o_ibuf_we, bus.o_ibuf_wr_data, bus.o_ibuf_addr,
              bus.o_fc_start, bus.o_err_drop};
      checks++;
      if (outs !== 9'd0) begin
         errors++;
         $display("FAIL reset_async got=%b exp=000000000", outs);
      end
      exp_q.delete();
      px = 0;
      step();
      step();
      rst   = 1'b1;
      wbase = writes;
      writes_at_start = -1;
      drive_vec({2'd2, 2'd3, 2'd0, 2'd1});
      for (int i = 0; i < 4; i++) step();
      drive_vec({2'd1, 2'd0, 2'd3, 2'd2});
      for (int i = 0; i < 3; i++) step();
      run_fc(2, idx);
      checks++;
      if (writes_at_start - wbase != IS || exp_q.size() != 0) begin
         errors++;
         $display("FAIL restart_full_image got writes_before_start=%0d pending=%0d exp %0d pending=0",
                  writes_at_start - wbase, exp_q.size(), IS);
      end
   endtask

   initial begin
      checks          = 0;
      errors          = 0;
      writes          = 0;
      writes_at_start = -1;
      px              = 0;
      test_reset();
      test_first_vector();
      test_image_complete();
      test_fc_busy_start();
      test_drop();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got pending=%0d exp=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
